// File: rtl/rr_slot_arbiter.sv
// Round-robin, time-sliced arbiter for four requesters sharing one resource.
// Every grant is followed by a one-cycle gap; a holder exceeding its slot is pre-empted.
module rr_slot_arbiter #(
  parameter int unsigned SLOT_CYCLES = 8,
  parameter int unsigned COUNT_W     = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [3:0]         req,
  output logic [3:0]         gnt,
  output logic               gnt_valid,
  output logic [1:0]         gnt_id,
  output logic [COUNT_W-1:0] slot_cnt,
  output logic               timeout
);

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    GAP
  } state_t;

  localparam logic [COUNT_W-1:0] SLOT_LAST = COUNT_W'(SLOT_CYCLES - 1);

  state_t             state_q;
  logic [3:0]         gnt_q;
  logic               gnt_valid_q;
  logic [1:0]         gnt_id_q;
  logic [1:0]         last_id_q;
  logic [COUNT_W-1:0] slot_q;
  logic               timeout_q;

  logic               win_found_d;
  logic [1:0]         win_id_d;
  logic [1:0]         cand_d;

  // Search starts one past the last holder, so the last holder ends up lowest priority.
  always_comb begin
    win_found_d = 1'b0;
    win_id_d    = '0;
    cand_d      = '0;
    for (int unsigned i = 1; i <= 4; i++) begin
      cand_d = last_id_q + 2'(i);
      if (!win_found_d && req[cand_d]) begin
        win_found_d = 1'b1;
        win_id_d    = cand_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      gnt_valid_q <= 1'b0;
      gnt_id_q    <= '0;
      last_id_q   <= 2'd3;
      slot_q      <= '0;
      timeout_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE, GAP: begin
          timeout_q <= 1'b0;
          slot_q    <= '0;
          if (win_found_d) begin
            state_q     <= GRANT;
            gnt_q       <= 4'b0001 << win_id_d;
            gnt_valid_q <= 1'b1;
            gnt_id_q    <= win_id_d;
            last_id_q   <= win_id_d;
          end else begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            gnt_valid_q <= 1'b0;
            gnt_id_q    <= '0;
          end
        end
        GRANT: begin
          // Release is checked first so a drop at the final slot cycle never flags timeout.
          if (!req[gnt_id_q] || (slot_q == SLOT_LAST)) begin
            state_q     <= GAP;
            gnt_q       <= '0;
            gnt_valid_q <= 1'b0;
            gnt_id_q    <= '0;
            slot_q      <= '0;
            timeout_q   <= req[gnt_id_q];
          end else begin
            slot_q    <= slot_q + COUNT_W'(1);
            timeout_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          gnt_q       <= '0;
          gnt_valid_q <= 1'b0;
          gnt_id_q    <= '0;
          slot_q      <= '0;
          timeout_q   <= 1'b0;
        end
      endcase
    end
  end

  assign gnt       = gnt_q;
  assign gnt_valid = gnt_valid_q;
  assign gnt_id    = gnt_id_q;
  assign slot_cnt  = slot_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_rr_slot_arbiter.sv
// Directed bench for rr_slot_arbiter: reset, single grant, rotation, release/timeout
// collision, wrap priority and reset mid-grant, checked with immediate assertions.
module tb_rr_slot_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] gnt;
  logic       gnt_valid;
  logic [1:0] gnt_id;
  logic [3:0] slot_cnt;
  logic       timeout;

  int unsigned total;
  int unsigned passed;
  int unsigned fails;

  rr_slot_arbiter #(
    .SLOT_CYCLES(8),
    .COUNT_W    (4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .gnt      (gnt),
    .gnt_valid(gnt_valid),
    .gnt_id   (gnt_id),
    .slot_cnt (slot_cnt),
    .timeout  (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] e_gnt, input logic [1:0] e_id,
                         input logic [3:0] e_slot, input logic e_to);
    chk({tag, ".gnt"},       32'(gnt),       32'(e_gnt));
    chk({tag, ".gnt_valid"}, 32'(gnt_valid), 32'(|e_gnt));
    chk({tag, ".gnt_id"},    32'(gnt_id),    32'(e_id));
    chk({tag, ".slot_cnt"},  32'(slot_cnt),  32'(e_slot));
    chk({tag, ".timeout"},   32'(timeout),   32'(e_to));
  endtask

  initial begin
    logic [1:0] order [5];
    total  = 0;
    passed = 0;
    fails  = 0;
    order  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

    // Reset / idle
    rst_n = 1'b0;
    req   = 4'b0000;
    step(); chk_all("rst0", 4'b0000, 2'd0, 4'd0, 1'b0);
    step(); chk_all("rst1", 4'b0000, 2'd0, 4'd0, 1'b0);
    rst_n = 1'b1;
    step(); chk_all("idle0", 4'b0000, 2'd0, 4'd0, 1'b0);
    step(); chk_all("idle1", 4'b0000, 2'd0, 4'd0, 1'b0);

    // Single request on line 2 for three cycles, then release
    req = 4'b0100;
    step(); chk_all("single0", 4'b0100, 2'd2, 4'd0, 1'b0);
    step(); chk_all("single1", 4'b0100, 2'd2, 4'd1, 1'b0);
    step(); chk_all("single2", 4'b0100, 2'd2, 4'd2, 1'b0);
    req = 4'b0000;
    step(); chk_all("single_gap", 4'b0000, 2'd0, 4'd0, 1'b0);
    step(); chk_all("single_idle", 4'b0000, 2'd0, 4'd0, 1'b0);

    // Fresh reset so requester 0 leads the rotation
    rst_n = 1'b0;
    step(); chk_all("rst2", 4'b0000, 2'd0, 4'd0, 1'b0);
    rst_n = 1'b1;

    // All four requesting: 0,1,2,3,0, each 8 cycles then a pre-empt gap
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      for (int k = 0; k < 8; k++) begin
        step();
        chk_all($sformatf("rr%0d_c%0d", g, k), 4'b0001 << order[g], order[g], 4'(k), 1'b0);
      end
      step();
      chk_all($sformatf("rr%0d_gap", g), 4'b0000, 2'd0, 4'd0, 1'b1);
    end

    // Release at the last slot cycle: gap without timeout (last holder 0, so 1 wins)
    req = 4'b0010;
    for (int k = 0; k < 8; k++) begin
      step();
      chk_all($sformatf("coll_c%0d", k), 4'b0010, 2'd1, 4'(k), 1'b0);
    end
    req = 4'b0000;
    step(); chk_all("coll_gap", 4'b0000, 2'd0, 4'd0, 1'b0);
    step(); chk_all("coll_idle", 4'b0000, 2'd0, 4'd0, 1'b0);

    // Wrap priority: holder 3 releases, 1001 present at the gap edge -> 0 wins
    req = 4'b1000;
    step(); chk_all("wrap_g0", 4'b1000, 2'd3, 4'd0, 1'b0);
    step(); chk_all("wrap_g1", 4'b1000, 2'd3, 4'd1, 1'b0);
    req = 4'b0001;
    step(); chk_all("wrap_gap", 4'b0000, 2'd0, 4'd0, 1'b0);
    req = 4'b1001;
    step(); chk_all("wrap_win", 4'b0001, 2'd0, 4'd0, 1'b0);

    // Reset mid-grant: holder 1 at slot 5 with 0011 held
    req = 4'b0010;
    step(); chk_all("mid_gap", 4'b0000, 2'd0, 4'd0, 1'b0);
    step(); chk_all("mid_g0", 4'b0010, 2'd1, 4'd0, 1'b0);
    req = 4'b0011;
    for (int k = 1; k <= 5; k++) begin
      step();
      chk_all($sformatf("mid_c%0d", k), 4'b0010, 2'd1, 4'(k), 1'b0);
    end
    rst_n = 1'b0;
    step(); chk_all("mid_rst", 4'b0000, 2'd0, 4'd0, 1'b0);
    rst_n = 1'b1;
    step(); chk_all("mid_after", 4'b0001, 2'd0, 4'd0, 1'b0);
    step(); chk_all("mid_after1", 4'b0001, 2'd0, 4'd1, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
